// File: rtl/graph_pkg.sv
// Shared types and default widths for the graph edge server.
package graph_pkg;

  localparam int unsigned DEF_NODE_IDX_WIDTH = 10;
  localparam int unsigned DEF_COUNTER_WIDTH  = 4;
  localparam int unsigned DEF_EDGE_DEPTH     = 2048;
  localparam int unsigned DEF_EA             = $clog2(DEF_EDGE_DEPTH);

  localparam logic [DEF_NODE_IDX_WIDTH-1:0] SINK_IDX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    SEND_END,
    WAIT_REQ,
    STREAM
  } state_t;

  typedef struct packed {
    logic [DEF_EA-1:0]            offset;
    logic [DEF_COUNTER_WIDTH-1:0] degree;
  } tbl_entry_t;

endpackage

// File: rtl/graph_edge_server_adj_mem.sv
// Node table and edge array: register arrays with synchronous writes and asynchronous reads.
module adj_mem
  import graph_pkg::*;
#(
  parameter int unsigned PARAM_NODE_IDX_WIDTH = DEF_NODE_IDX_WIDTH,
  parameter int unsigned PARAM_COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
  parameter int unsigned PARAM_EDGE_DEPTH     = DEF_EDGE_DEPTH
) (
  input  logic                                clk,
  input  logic                                tbl_wr_en,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     tbl_wr_addr,
  input  logic [$clog2(PARAM_EDGE_DEPTH)-1:0] tbl_wr_offset,
  input  logic [PARAM_COUNTER_WIDTH-1:0]      tbl_wr_degree,
  input  logic                                edge_wr_en,
  input  logic [$clog2(PARAM_EDGE_DEPTH)-1:0] edge_wr_addr,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     edge_wr_data,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     tbl_rd_addr,
  output logic [$clog2(PARAM_EDGE_DEPTH)-1:0] tbl_rd_offset,
  output logic [PARAM_COUNTER_WIDTH-1:0]      tbl_rd_degree,
  input  logic [$clog2(PARAM_EDGE_DEPTH)-1:0] edge_rd_addr,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]     edge_rd_data
);

  localparam int unsigned EA = $clog2(PARAM_EDGE_DEPTH);
  localparam int unsigned NODES = 2 ** PARAM_NODE_IDX_WIDTH;

  typedef struct packed {
    logic [EA-1:0]                  offset;
    logic [PARAM_COUNTER_WIDTH-1:0] degree;
  } entry_t;

  entry_t                          tbl [NODES];
  logic [PARAM_NODE_IDX_WIDTH-1:0] edges [PARAM_EDGE_DEPTH];

  // No reset: contents survive a run abort.
  always_ff @(posedge clk) begin
    if (tbl_wr_en) begin
      tbl[tbl_wr_addr] <= '{offset: tbl_wr_offset, degree: tbl_wr_degree};
    end
    if (edge_wr_en) begin
      edges[edge_wr_addr] <= edge_wr_data;
    end
  end

  always_comb begin
    tbl_rd_offset = tbl[tbl_rd_addr].offset;
    tbl_rd_degree = tbl[tbl_rd_addr].degree;
    edge_rd_data  = edges[edge_rd_addr];
  end

endmodule

// File: rtl/graph_edge_server.sv
// Adjacency-list responder: presents start/end indices, then streams successor lists
// with a count-down counter for the traversal FSM.
module graph_edge_server
  import graph_pkg::*;
#(
  parameter int unsigned PARAM_NODE_IDX_WIDTH = DEF_NODE_IDX_WIDTH,
  parameter int unsigned PARAM_COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
  parameter int unsigned PARAM_EDGE_DEPTH     = DEF_EDGE_DEPTH,
  parameter logic [PARAM_NODE_IDX_WIDTH-1:0] PARAM_SINK_IDX = '1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_run,
  input  logic                                part_sel,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     p1_start_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     p1_end_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     p2_start_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     p2_end_idx,
  input  logic                                tbl_wr_en,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     tbl_wr_addr,
  input  logic [$clog2(PARAM_EDGE_DEPTH)-1:0] tbl_wr_offset,
  input  logic [PARAM_COUNTER_WIDTH-1:0]      tbl_wr_degree,
  input  logic                                edge_wr_en,
  input  logic [$clog2(PARAM_EDGE_DEPTH)-1:0] edge_wr_addr,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     edge_wr_data,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]     node_idx_reg,
  input  logic                                rd_next_node_reg,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]     next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]      next_node_counter
);

  localparam int unsigned EA = $clog2(PARAM_EDGE_DEPTH);
  localparam int unsigned CW = PARAM_COUNTER_WIDTH;
  localparam int unsigned NW = PARAM_NODE_IDX_WIDTH;

  state_t        state_q, state_n;
  logic [EA-1:0] ptr_q, ptr_n;
  logic [CW-1:0] rem_q, rem_n;
  logic [NW-1:0] idx_q, idx_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic          wr_allow;
  logic [EA-1:0] tbl_offset;
  logic [CW-1:0] tbl_degree;
  logic [EA-1:0] edge_addr;
  logic [NW-1:0] edge_data;

  // Explicit wrap so non-power-of-two edge depths stay in range.
  function automatic logic [EA-1:0] ptr_inc(input logic [EA-1:0] p);
    if (p == EA'(PARAM_EDGE_DEPTH - 1)) begin
      return '0;
    end
    return p + EA'(1);
  endfunction

  assign wr_allow  = !start_run || (state_q == IDLE);
  assign edge_addr = (state_q == STREAM) ? ptr_q : tbl_offset;

  adj_mem #(
    .PARAM_NODE_IDX_WIDTH (PARAM_NODE_IDX_WIDTH),
    .PARAM_COUNTER_WIDTH  (PARAM_COUNTER_WIDTH),
    .PARAM_EDGE_DEPTH     (PARAM_EDGE_DEPTH)
  ) u_adj_mem (
    .clk           (clk),
    .tbl_wr_en     (tbl_wr_en && wr_allow),
    .tbl_wr_addr   (tbl_wr_addr),
    .tbl_wr_offset (tbl_wr_offset),
    .tbl_wr_degree (tbl_wr_degree),
    .edge_wr_en    (edge_wr_en && wr_allow),
    .edge_wr_addr  (edge_wr_addr),
    .edge_wr_data  (edge_wr_data),
    .tbl_rd_addr   (node_idx_reg),
    .tbl_rd_offset (tbl_offset),
    .tbl_rd_degree (tbl_degree),
    .edge_rd_addr  (edge_addr),
    .edge_rd_data  (edge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      rem_q   <= rem_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
    end
  end

  // Hold-by-default gives the start_run freeze for free.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    rem_n   = rem_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    if (start_run) begin
      unique case (state_q)
        IDLE: begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = SEND_START;
        end
        SEND_START: begin
          idx_n   = part_sel ? p2_start_idx : p1_start_idx;
          cnt_n   = '0;
          state_n = SEND_END;
        end
        SEND_END: begin
          idx_n   = part_sel ? p2_end_idx : p1_end_idx;
          cnt_n   = '0;
          state_n = WAIT_REQ;
        end
        WAIT_REQ: begin
          cnt_n = '0;
          if (rd_next_node_reg) begin
            if (tbl_degree != '0) begin
              ptr_n = ptr_inc(tbl_offset);
              rem_n = tbl_degree - CW'(1);
              idx_n = edge_data;
              cnt_n = tbl_degree;
              if (tbl_degree != CW'(1)) begin
                state_n = STREAM;
              end
            end else begin
              idx_n = PARAM_SINK_IDX;
              cnt_n = CW'(1);
            end
          end
        end
        STREAM: begin
          idx_n = edge_data;
          cnt_n = rem_q;
          ptr_n = ptr_inc(ptr_q);
          rem_n = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_n = WAIT_REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign next_node_idx     = idx_q;
  assign next_node_counter = cnt_q;

endmodule

// File: tb/tb_graph_edge_server.sv
// Directed bench for graph_edge_server: start/end sequencing, list streaming, wrap, freeze, reset.
module tb_graph_edge_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_run = 1'b0;
  logic        part_sel = 1'b0;
  logic [9:0]  p1_start_idx = '0, p1_end_idx = '0, p2_start_idx = '0, p2_end_idx = '0;
  logic        tbl_wr_en = 1'b0;
  logic [9:0]  tbl_wr_addr = '0;
  logic [10:0] tbl_wr_offset = '0;
  logic [3:0]  tbl_wr_degree = '0;
  logic        edge_wr_en = 1'b0;
  logic [10:0] edge_wr_addr = '0;
  logic [9:0]  edge_wr_data = '0;
  logic [9:0]  node_idx_reg = '0;
  logic        rd_next_node_reg = 1'b0;
  logic [9:0]  next_node_idx;
  logic [3:0]  next_node_counter;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  graph_edge_server dut (
    .clk               (clk),
    .rst               (rst),
    .start_run         (start_run),
    .part_sel          (part_sel),
    .p1_start_idx      (p1_start_idx),
    .p1_end_idx        (p1_end_idx),
    .p2_start_idx      (p2_start_idx),
    .p2_end_idx        (p2_end_idx),
    .tbl_wr_en         (tbl_wr_en),
    .tbl_wr_addr       (tbl_wr_addr),
    .tbl_wr_offset     (tbl_wr_offset),
    .tbl_wr_degree     (tbl_wr_degree),
    .edge_wr_en        (edge_wr_en),
    .edge_wr_addr      (edge_wr_addr),
    .edge_wr_data      (edge_wr_data),
    .node_idx_reg      (node_idx_reg),
    .rd_next_node_reg  (rd_next_node_reg),
    .next_node_idx     (next_node_idx),
    .next_node_counter (next_node_counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both outputs after the next clock edge.
  task automatic beat(input string tag, input int unsigned idx, input int unsigned cnt);
    tick();
    check({tag, ".idx"}, next_node_idx, idx);
    check({tag, ".cnt"}, next_node_counter, cnt);
  endtask

  task automatic wr_tbl(input int unsigned addr, input int unsigned off, input int unsigned deg);
    tbl_wr_en = 1'b1; tbl_wr_addr = 10'(addr); tbl_wr_offset = 11'(off); tbl_wr_degree = 4'(deg);
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic wr_edge(input int unsigned addr, input int unsigned data);
    edge_wr_en = 1'b1; edge_wr_addr = 11'(addr); edge_wr_data = 10'(data);
    tick();
    edge_wr_en = 1'b0;
  endtask

  task automatic request(input int unsigned node);
    rd_next_node_reg = 1'b1;
    node_idx_reg     = 10'(node);
  endtask

  initial begin
    // Graph load while start_run is low.
    wr_tbl(5, 10, 3);
    wr_edge(10, 7); wr_edge(11, 8); wr_edge(12, 9);
    wr_tbl(7, 13, 1);
    wr_edge(13, 9);
    wr_tbl(9, 0, 0);
    wr_tbl(20, 2046, 4);
    wr_edge(2046, 100); wr_edge(2047, 101); wr_edge(0, 102); wr_edge(1, 103);
    wr_tbl(30, 200, 5);
    for (int unsigned i = 0; i < 5; i++) wr_edge(200 + i, 300 + i);

    check("reset.idx", next_node_idx, 0);
    check("reset.cnt", next_node_counter, 0);
    rst = 1'b0;
    part_sel = 1'b0;
    p1_start_idx = 10'd5; p1_end_idx = 10'd9;
    p2_start_idx = 10'd1; p2_end_idx = 10'd2;
    start_run = 1'b1;

    beat("run.c0", 0, 0);
    beat("run.start", 5, 0);
    beat("run.end", 9, 0);

    request(5);
    beat("n5.b1", 7, 3);
    rd_next_node_reg = 1'b0;
    beat("n5.b2", 8, 2);
    beat("n5.b3", 9, 1);
    request(7);
    beat("n7.b1", 9, 1);
    rd_next_node_reg = 1'b0;
    beat("n7.idle", 9, 0);

    request(9);
    beat("n9.sink", 10'h3FF, 1);
    rd_next_node_reg = 1'b0;
    beat("n9.idle", 10'h3FF, 0);

    request(20);
    beat("wrap.b1", 100, 4);
    rd_next_node_reg = 1'b0;
    beat("wrap.b2", 101, 3);
    start_run = 1'b0;
    for (int unsigned i = 0; i < 3; i++) beat("freeze", 101, 3);
    start_run = 1'b1;
    beat("wrap.b3", 102, 2);
    beat("wrap.b4", 103, 1);
    beat("wrap.idle", 103, 0);

    request(30);
    beat("n30.b1", 300, 5);
    rd_next_node_reg = 1'b0;
    beat("n30.b2", 301, 4);
    #2 rst = 1'b1;
    #1;
    check("arst.idx", next_node_idx, 0);
    check("arst.cnt", next_node_counter, 0);
    tick();
    rst = 1'b0;

    beat("rerun.c0", 0, 0);
    beat("rerun.start", 5, 0);
    beat("rerun.end", 9, 0);

    // Outside IDLE with start_run high this write must be dropped.
    wr_tbl(5, 13, 1);
    request(30);
    for (int unsigned i = 0; i < 5; i++) begin
      beat("rerun.n30", 300 + i, 5 - i);
      rd_next_node_reg = 1'b0;
    end
    request(5);
    beat("rerun.n5.b1", 7, 3);
    rd_next_node_reg = 1'b0;
    beat("rerun.n5.b2", 8, 2);
    beat("rerun.n5.b3", 9, 1);
    beat("rerun.idle", 9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
